// File: rtl/button_blip_if.sv
// ============================================================================
//  Module      : button_blip_if
//  Description : Board-button bundle between the raw pushbuttons and the
//                button conditioning stage. Carries the three raw buttons in
//                and the conditioned blips and debounced levels out.
//  Modports    : master - button/board side (drives raw buttons)
//                slave  - conditioning stage (consumes buttons, drives blips)
//  Signals     : btnUp, btnDown, btnStart - raw, asynchronous, active-high
//                userUp, userDown, start  - single-cycle blips
//                btnLevel[2:0]            - debounced levels {start,down,up}
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_blip_if;
    logic       btnUp;
    logic       btnDown;
    logic       btnStart;
    logic       userUp;
    logic       userDown;
    logic       start;
    logic [2:0] btnLevel;

    modport master (
        output btnUp, btnDown, btnStart,
        input  userUp, userDown, start, btnLevel
    );

    modport slave (
        input  btnUp, btnDown, btnStart,
        output userUp, userDown, start, btnLevel
    );
endinterface

`default_nettype wire

// File: rtl/button_blip.sv
// ============================================================================
//  Module      : button_blip
//  Description : Synchronizes, debounces and edge-detects the up, down and
//                start pushbuttons, producing single-cycle blips for the user
//                counter and the starter. Up and down blips that would fire
//                on the same cycle cancel each other; start is unaffected.
//  Ports       : Clk100M - system clock (only clock)
//                RstN    - asynchronous active-low reset
//                bus     - button_blip_if.slave (raw buttons in, blips and
//                          debounced levels out)
//  Parameters  : DEBOUNCE_CYCLES - stable cycles to accept press/release (>=2)
//                REPEAT_DELAY    - hold cycles before first auto-repeat blip
//                REPEAT_PERIOD   - cycles between further auto-repeat blips
//  Options     : BUTTON_REPEAT_EN - when defined, held up/down buttons
//                auto-repeat; when undefined exactly one blip per press.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_blip #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic         Clk100M,
    input  logic         RstN,
    button_blip_if.slave bus
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // Reject configurations the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_blip: illegal parameter value");
    end

    // Channel order everywhere: [0]=up, [1]=down, [2]=start.
    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_cand;     // press accepted this cycle
    logic [2:0] w_rep;      // auto-repeat due this cycle
    logic [2:0] w_level;
    logic       r_user_up;
    logic       r_user_down;
    logic       r_start;

    assign w_raw = {bus.btnStart, bus.btnDown, bus.btnUp};

    // Two-flop synchronizer per raw button.
    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_chan
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             w_s;

        assign w_s = r_sync2[g];

        // Debounce FSM: a press or release is accepted only after the
        // synchronized input has held its new value for the full window.
        always_ff @(posedge Clk100M or negedge RstN) begin
            if (!RstN) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_s) begin
                            r_state <= ST_PRESS_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!w_s) begin
                            r_state <= ST_IDLE;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= ST_PRESSED;
                            r_level <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_s) begin
                            r_state <= ST_RELEASE_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (w_s) begin
                            r_state <= ST_PRESSED;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= ST_IDLE;
                            r_level <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_level <= 1'b0;
                    end
                endcase
            end
        end

        // Candidate is decoded on the accepting edge itself so the
        // registered blip appears together with the PRESSED state.
        assign w_cand[g]  = (r_state == ST_PRESS_WAIT) && w_s && (r_cnt == CNT_LAST);
        assign w_level[g] = r_level;

`ifdef BUTTON_REPEAT_EN
        if (g < 2) begin : g_rep
            logic [REP_W-1:0] r_rcnt;
            logic             r_first_done;
            logic             w_enter;
            logic             w_rep_hit;

            // Any entry into PRESSED (fresh press or recovered release
            // bounce) restarts the repeat schedule from the initial delay.
            assign w_enter   = w_cand[g] || ((r_state == ST_RELEASE_WAIT) && w_s);
            assign w_rep_hit = (r_state == ST_PRESSED) &&
                               (r_first_done ? (r_rcnt == REP_W'(REPEAT_PERIOD - 1))
                                             : (r_rcnt == REP_W'(REPEAT_DELAY - 1)));

            always_ff @(posedge Clk100M or negedge RstN) begin
                if (!RstN) begin
                    r_rcnt       <= '0;
                    r_first_done <= 1'b0;
                end else if (w_enter) begin
                    r_rcnt       <= '0;
                    r_first_done <= 1'b0;
                end else if (r_state == ST_PRESSED) begin
                    if (w_rep_hit) begin
                        r_rcnt       <= '0;
                        r_first_done <= 1'b1;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
            end

            assign w_rep[g] = w_rep_hit;
        end else begin : g_norep
            assign w_rep[g] = 1'b0;
        end
`endif
    end

`ifndef BUTTON_REPEAT_EN
    assign w_rep = 3'b000;
`endif

    // Registered blips; simultaneous up and down requests cancel.
    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            r_user_up   <= 1'b0;
            r_user_down <= 1'b0;
            r_start     <= 1'b0;
        end else begin
            r_user_up   <= (w_cand[0] | w_rep[0]) & ~(w_cand[1] | w_rep[1]);
            r_user_down <= (w_cand[1] | w_rep[1]) & ~(w_cand[0] | w_rep[0]);
            r_start     <= w_cand[2];
        end
    end

    assign bus.userUp   = r_user_up;
    assign bus.userDown = r_user_down;
    assign bus.start    = r_start;
    assign bus.btnLevel = w_level;

endmodule

`default_nettype wire

// File: tb/tb_button_blip.sv
// ============================================================================
//  Module      : tb_button_blip
//  Description : Self-checking bench for button_blip. A reference model
//                tracks, per button, the run length of synchronized samples
//                that disagree with the accepted level and pushes the
//                expected outputs for every clock into a scoreboard queue;
//                a monitor pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_button_blip;

    localparam int DEB  = 4;
    localparam int RDEL = 10;
    localparam int RPER = 5;

    logic Clk100M = 1'b0;
    logic RstN    = 1'b0;

    button_blip_if bif();

    button_blip #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDEL),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .Clk100M (Clk100M),
        .RstN    (RstN),
        .bus     (bif.slave)
    );

    always #5 Clk100M = ~Clk100M;

    typedef struct packed {
        logic       up;
        logic       dn;
        logic       st;
        logic [2:0] lvl;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [2:0] m_d1  = 3'b000;
    logic [2:0] m_d2  = 3'b000;
    logic [2:0] m_lvl = 3'b000;
    int         m_run [3];   // consecutive samples disagreeing with level
    int         m_k   [3];   // edges spent continuously pressed

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual {up,dn,st,lvl}=%b required=%b", name, $time, act, req);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bif.userUp, bif.userDown, bif.start, bif.btnLevel};
    endfunction

    task automatic set_btn(input logic [2:0] v);
        bif.btnUp    = v[0];
        bif.btnDown  = v[1];
        bif.btnStart = v[2];
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk100M);
        #2;
    endtask

    // Reference model: a button's level flips once DEB+1 consecutive
    // synchronized samples disagree with it; a 0->1 flip is a press blip.
    always @(posedge Clk100M or negedge RstN) begin
        logic [2:0] raw;
        logic [2:0] s;
        logic [2:0] flip;
        logic [2:0] rep;
        logic       cu;
        logic       cd;
        exp_t       e;
        if (!RstN) begin
            m_d1  = 3'b000;
            m_d2  = 3'b000;
            m_lvl = 3'b000;
            for (int c = 0; c < 3; c++) begin
                m_run[c] = 0;
                m_k[c]   = 0;
            end
            q.delete();
        end else begin
            raw  = {bif.btnStart, bif.btnDown, bif.btnUp};
            s    = m_d2;
            m_d2 = m_d1;
            m_d1 = raw;
            for (int c = 0; c < 3; c++) begin
                rep[c]  = 1'b0;
                flip[c] = 1'b0;
                if (m_lvl[c] && m_run[c] == 0) begin
                    m_k[c]++;
`ifdef BUTTON_REPEAT_EN
                    if (c < 2 && m_k[c] >= RDEL && ((m_k[c] - RDEL) % RPER) == 0)
                        rep[c] = 1'b1;
`endif
                end
                if (s[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB + 1) begin
                        m_lvl[c] = s[c];
                        m_run[c] = 0;
                        flip[c]  = s[c];
                        m_k[c]   = 0;
                    end
                end else begin
                    if (m_lvl[c] && m_run[c] != 0) m_k[c] = 0;
                    m_run[c] = 0;
                end
            end
            cu    = flip[0] | rep[0];
            cd    = flip[1] | rep[1];
            e.up  = cu & ~cd;
            e.dn  = cd & ~cu;
            e.st  = flip[2];
            e.lvl = m_lvl;
            q.push_back(e);
        end
    end

    // Scoreboard monitor
    always @(negedge Clk100M) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("cycle_outputs", outs(), e);
        end
    end

    initial begin
        int         hold [3];
        logic [2:0] v;
        logic [4:0] bounce;

        set_btn(3'b000);
        RstN = 1'b0;
        step(2);
        chk("reset_state", outs(), 6'b000000);
        RstN = 1'b1;
        step(2);

        // Up held 20 cycles
        set_btn(3'b001); step(20); set_btn(3'b000); step(15);

        // Down bounces 1,0,1,0,1 then holds
        bounce = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            set_btn({1'b0, bounce[i], 1'b0});
            step(1);
        end
        step(14); set_btn(3'b000); step(15);

        // Up and down together: mutual exclusion
        set_btn(3'b011); step(20); set_btn(3'b000); step(15);

        // Release bounce of two cycles
        set_btn(3'b001); step(12); set_btn(3'b000); step(2);
        set_btn(3'b001); step(12); set_btn(3'b000); step(15);

        // Start held through reset deassertion
        set_btn(3'b100); RstN = 1'b0; step(3);
        chk("reset_held_start", outs(), 6'b000000);
        RstN = 1'b1; step(15); set_btn(3'b000); step(15);

        // Reset during PRESS_WAIT, button stays held and re-qualifies
        set_btn(3'b001); step(4);
        RstN = 1'b0; #1;
        chk("reset_press_wait", outs(), 6'b000000);
        step(2); RstN = 1'b1; step(15); set_btn(3'b000); step(15);

        // Latency of first blip, then reset while the blip is high
        set_btn(3'b001);
        repeat (DEB + 3) @(posedge Clk100M);
        #1;
        chk("blip_latency", outs(), 6'b100001);
        RstN = 1'b0; #1;
        chk("reset_mid_blip", outs(), 6'b000000);
        step(1); RstN = 1'b1; step(15); set_btn(3'b000); step(15);

        // Long holds (auto-repeat on up when enabled, never on start)
        set_btn(3'b001); step(40); set_btn(3'b000); step(15);
        set_btn(3'b100); step(40); set_btn(3'b000); step(15);

        // Randomized bouncy buttons
        v = 3'b000;
        for (int c = 0; c < 3; c++) hold[c] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (hold[c] == 0) begin
                    v[c]    = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 45))
                                                          : int'($urandom_range(1, 5));
                end
                hold[c]--;
            end
            if ($urandom_range(0, 29) == 0) begin
                v[1]    = v[0];
                hold[1] = hold[0];
            end
            set_btn(v);
            step(1);
        end
        set_btn(3'b000);
        step(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
